// File: rtl/param_nbit_processor.sv
// Parametrised manual/run-mode processor with on-chip program memory, carry/zero flags and Done/busy handshakes.
// Optional SHL instruction on CTL func 11 is enabled by defining PROC_SHIFT_EN.
module param_nbit_processor #(
  parameter int DATA_W = 4,
  parameter int REG_AW = 2,
  parameter int PC_W   = 4,
  localparam int INSTR_W = 2 + REG_AW + DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               execute,
  input  logic               switch_mode,
  input  logic               pc_enable,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [DATA_W-1:0]  LEDs,
  output logic               Done,
  output logic               busy,
  output logic               carry,
  output logic               zero,
  output logic [PC_W-1:0]    pc
);

  localparam int NREGS      = 2 ** REG_AW;
  localparam int PROG_DEPTH = 2 ** PC_W;
  localparam logic [PC_W-1:0] PC_LAST  = PC_W'(PROG_DEPTH - 1);
  localparam logic [PC_W-1:0] PC_LAST2 = PC_W'(PROG_DEPTH - 2);

  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_MOV = 2'b01;
  localparam logic [1:0] OP_ALU = 2'b10;
  localparam logic [1:0] OP_CTL = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]   leds_q, leds_d;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;
  logic                exec_q, exec_d;
  logic                mode_q, mode_d;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   regs_d [NREGS];

  logic [INSTR_W-1:0]  mem [PROG_DEPTH];
  logic [INSTR_W-1:0]  ir_q;
  logic                ir_load_mem, ir_load_port;

  logic                start;
  logic [1:0]          op;
  logic [REG_AW-1:0]   rd, rs;
  logic [DATA_W-1:0]   imm;
  logic [1:0]          func;
  logic [DATA_W-1:0]   rd_val, rs_val;

  assign start  = execute & ~exec_q;
  assign op     = ir_q[INSTR_W-1 -: 2];
  assign rd     = ir_q[DATA_W +: REG_AW];
  assign imm    = ir_q[DATA_W-1:0];
  assign rs     = imm[DATA_W-1 -: REG_AW];
  assign func   = imm[1:0];
  assign rd_val = regs_q[rd];
  assign rs_val = regs_q[rs];

  assign busy  = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign Done  = (state_q == S_DONE);
  assign LEDs  = leds_q;
  assign carry = carry_q;
  assign zero  = zero_q;
  assign pc    = pc_q;

  // Program memory and instruction register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) begin
      mem[prog_addr] <= prog_data;
    end
    if (ir_load_mem) begin
      ir_q <= mem[pc_q];
    end else if (ir_load_port) begin
      ir_q <= instruction;
    end
  end

  always_comb begin
    logic [DATA_W:0]   alu_sum;
    logic [DATA_W-1:0] alu_res;
    logic              is_halt;
    logic              bz_taken;

    state_d      = state_q;
    pc_d         = pc_q;
    leds_d       = leds_q;
    carry_d      = carry_q;
    zero_d       = zero_q;
    exec_d       = execute;
    mode_d       = mode_q;
    regs_d       = regs_q;
    ir_load_mem  = 1'b0;
    ir_load_port = 1'b0;
    alu_sum      = '0;
    alu_res      = '0;
    is_halt      = 1'b0;
    bz_taken     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = switch_mode;
          if (switch_mode) begin
            ir_load_port = 1'b1;
            state_d      = S_EXEC;
          end else begin
            pc_d    = '0;
            state_d = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        if (pc_enable) begin
          ir_load_mem = 1'b1;
          state_d     = S_EXEC;
        end
      end

      S_EXEC: begin
        unique case (op)
          OP_LDI: regs_d[rd] = imm;
          OP_MOV: regs_d[rd] = rs_val;
          OP_ALU: begin
            unique case (func)
              2'b00: begin
                alu_sum = {1'b0, rd_val} + {1'b0, rs_val};
                alu_res = alu_sum[DATA_W-1:0];
                carry_d = alu_sum[DATA_W];
              end
              2'b01: begin
                alu_res = rd_val - rs_val;
                carry_d = (rd_val < rs_val);
              end
              2'b10: begin
                alu_res = rd_val & rs_val;
                carry_d = 1'b0;
              end
              default: begin
                alu_res = rd_val ^ rs_val;
                carry_d = 1'b0;
              end
            endcase
            regs_d[rd] = alu_res;
            zero_d     = (alu_res == '0);
          end
          OP_CTL: begin
            unique case (func)
              2'b00: leds_d   = rd_val;
              2'b01: is_halt  = 1'b1;
              2'b10: bz_taken = zero_q;
              default: begin
`ifdef PROC_SHIFT_EN
                alu_res    = {rd_val[DATA_W-2:0], 1'b0};
                regs_d[rd] = alu_res;
                carry_d    = rd_val[DATA_W-1];
                zero_d     = (alu_res == '0);
`endif
              end
            endcase
          end
          default: ;
        endcase

        // Run mode never wraps: the last address or an overflowing skip ends the program.
        if (mode_q) begin
          state_d = S_DONE;
        end else if (is_halt || pc_q == PC_LAST) begin
          state_d = S_DONE;
        end else if (bz_taken) begin
          if (pc_q == PC_LAST2) begin
            pc_d    = PC_LAST;
            state_d = S_DONE;
          end else begin
            pc_d    = pc_q + PC_W'(2);
            state_d = S_FETCH;
          end
        end else begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH;
        end
      end

      S_DONE: begin
        if (!execute) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      leds_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      exec_q  <= 1'b0;
      mode_q  <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      leds_q  <= leds_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      exec_q  <= exec_d;
      mode_q  <= mode_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: tb/tb_param_nbit_processor.sv
// Directed bench for param_nbit_processor: table of manual-mode vectors, then run-mode, stall, abort and no-HALT sequences.
module tb_param_nbit_processor;

  logic       clk = 1'b0;
  logic       reset;
  logic       execute;
  logic       switch_mode;
  logic       pc_enable;
  logic [7:0] instruction;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [3:0] LEDs;
  logic       Done;
  logic       busy;
  logic       carry;
  logic       zero;
  logic [3:0] pc;

  int checks = 0;
  int errors = 0;

`ifdef PROC_SHIFT_EN
  localparam logic SH = 1'b1;
`else
  localparam logic SH = 1'b0;
`endif

  param_nbit_processor dut (
    .clk(clk), .reset(reset), .execute(execute), .switch_mode(switch_mode),
    .pc_enable(pc_enable), .instruction(instruction), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .LEDs(LEDs), .Done(Done),
    .busy(busy), .carry(carry), .zero(zero), .pc(pc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0] instr;
    logic [3:0] leds;
    logic       c;
    logic       z;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic manual_exec(input logic [7:0] ins);
    @(negedge clk);
    switch_mode = 1'b1;
    instruction = ins;
    execute     = 1'b1;
    @(posedge clk); #1;
    chk("man_busy_after_start", {busy, Done}, 2'b10);
    @(negedge clk);
    instruction = ~ins;
    @(posedge clk); #1;
    chk("man_done_2cyc", {busy, Done}, 2'b01);
    @(negedge clk);
    execute = 1'b0;
    @(posedge clk); #1;
    chk("man_done_clear", Done, 1'b0);
  endtask

  task automatic load_prog(input logic [7:0] img [16]);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = 4'(i);
      prog_data = img[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clk);
    switch_mode = 1'b0;
    pc_enable   = 1'b1;
    execute     = 1'b1;
    @(posedge clk); #1;
    chk("run_start_pc", {busy, pc}, {1'b1, 4'd0});
  endtask

  task automatic wait_done(input int budget, output int cycles, output logic busy_ok);
    cycles  = 0;
    busy_ok = 1'b1;
    while (cycles < budget) begin
      @(posedge clk);
      cycles++;
      #1;
      if (Done) break;
      if (!busy) busy_ok = 1'b0;
    end
    chk("run_done_reached", Done, 1'b1);
  endtask

  task automatic finish_run();
    chk("run_done_not_busy", busy, 1'b0);
    @(negedge clk);
    execute = 1'b0;
    @(posedge clk); #1;
    chk("run_done_clear", Done, 1'b0);
  endtask

  logic [7:0] prog_a [16];
  logic [7:0] prog_nop [16];
  int         cyc, cyc2;
  logic       bok;
  logic [3:0] saved_pc;
  logic       stall_ok;

  initial begin
    vecs[0]  = '{8'b00001010, 4'h0, 1'b0, 1'b0};
    vecs[1]  = '{8'b00010101, 4'h0, 1'b0, 1'b0};
    vecs[2]  = '{8'b10000100, 4'h0, 1'b0, 1'b0};
    vecs[3]  = '{8'b11000000, 4'hF, 1'b0, 1'b0};
    vecs[4]  = '{8'b00001111, 4'hF, 1'b0, 1'b0};
    vecs[5]  = '{8'b00010001, 4'hF, 1'b0, 1'b0};
    vecs[6]  = '{8'b10000100, 4'hF, 1'b1, 1'b1};
    vecs[7]  = '{8'b11000000, 4'h0, 1'b1, 1'b1};
    vecs[8]  = '{8'b00100111, 4'h0, 1'b1, 1'b1};
    vecs[9]  = '{8'b00000011, 4'h0, 1'b1, 1'b1};
    vecs[10] = '{8'b00010101, 4'h0, 1'b1, 1'b1};
    vecs[11] = '{8'b10000101, 4'h0, 1'b1, 1'b0};
    vecs[12] = '{8'b11000000, 4'hE, 1'b1, 1'b0};
    vecs[13] = '{8'b10000011, 4'hE, 1'b0, 1'b1};
    vecs[14] = '{8'b11000000, 4'h0, 1'b0, 1'b1};
    vecs[15] = '{8'b00011100, 4'h0, 1'b0, 1'b1};
    vecs[16] = '{8'b00101010, 4'h0, 1'b0, 1'b1};
    vecs[17] = '{8'b10011010, 4'h0, 1'b0, 1'b0};
    vecs[18] = '{8'b11010000, 4'h8, 1'b0, 1'b0};
    vecs[19] = '{8'b01110100, 4'h8, 1'b0, 1'b0};
    vecs[20] = '{8'b11110000, 4'h8, 1'b0, 1'b0};
    vecs[21] = '{8'b10100101, 4'h8, 1'b0, 1'b0};
    vecs[22] = '{8'b11100000, 4'h2, 1'b0, 1'b0};
    vecs[23] = '{8'b11000011, 4'h2, 1'b0, SH};
    vecs[24] = '{8'b11000001, 4'h2, 1'b0, SH};
    vecs[25] = '{8'b11000010, 4'h2, 1'b0, SH};

    for (int i = 0; i < 16; i++) begin
      prog_a[i]   = 8'b11000011;
      prog_nop[i] = 8'b11000011;
    end
    prog_a[0] = 8'b00100001;
    prog_a[1] = 8'b00110001;
    prog_a[2] = 8'b10101101;
    prog_a[3] = 8'b11000010;
    prog_a[4] = 8'b11110000;
    prog_a[5] = 8'b11100000;
    prog_a[6] = 8'b11000001;

    reset = 1'b0; execute = 1'b0; switch_mode = 1'b1; pc_enable = 1'b1;
    instruction = '0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {LEDs, Done, busy, carry, zero, pc}, 12'h000);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 26; i++) begin
      manual_exec(vecs[i].instr);
      $display("vec %0d instr=%b leds=%b carry=%b zero=%b", i, vecs[i].instr, LEDs, carry, zero);
      chk($sformatf("vec%0d_leds", i), LEDs, vecs[i].leds);
      chk($sformatf("vec%0d_flags", i), {carry, zero}, {vecs[i].c, vecs[i].z});
    end

`ifdef PROC_SHIFT_EN
    manual_exec(8'b00001001);
    manual_exec(8'b11000011);
    chk("shl_flags", {carry, zero}, 2'b10);
    manual_exec(8'b11000000);
    chk("shl_result", LEDs, 4'b0010);
    $display("shl r0=1001 -> leds=%b carry=%b zero=%b", LEDs, carry, zero);
`endif

    load_prog(prog_a);
    start_run();
    wait_done(40, cyc, bok);
    $display("run program cycles=%0d pc=%0d leds=%b", cyc, pc, LEDs);
    chk("run_cycles", cyc, 12);
    chk("run_busy_throughout", bok, 1'b1);
    chk("run_pc_halt", pc, 4'd6);
    chk("run_leds_skip", LEDs, 4'b0000);
    chk("run_flags", {carry, zero}, 2'b01);
    finish_run();

    manual_exec(8'b11010000);
    chk("pre_stall_leds", LEDs, 4'h8);
    start_run();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    pc_enable = 1'b0;
    saved_pc  = pc;
    stall_ok  = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (pc !== saved_pc || busy !== 1'b1 || Done !== 1'b0) stall_ok = 1'b0;
    end
    chk("stall_pc_frozen", stall_ok, 1'b1);
    chk("stall_pc_value", saved_pc, 4'd1);
    @(negedge clk);
    pc_enable = 1'b1;
    wait_done(40, cyc2, bok);
    $display("stall run cycles=%0d pc=%0d leds=%b", 7 + cyc2, pc, LEDs);
    chk("stall_cycles", 7 + cyc2, 17);
    chk("stall_busy", bok, 1'b1);
    chk("stall_leds", LEDs, 4'b0000);
    chk("stall_pc", pc, 4'd6);
    finish_run();

    manual_exec(8'b11010000);
    chk("pre_abort_leds", LEDs, 4'h8);
    start_run();
    repeat (5) @(posedge clk);
    #1;
    chk("pre_abort_pc", pc, 4'd2);
    #1;
    reset = 1'b0;
    #1;
    $display("abort leds=%b pc=%0d Done=%b busy=%b", LEDs, pc, Done, busy);
    chk("abort_state", {LEDs, pc, Done, busy}, 10'h000);
    @(negedge clk);
    execute = 1'b0;
    reset   = 1'b1;
    manual_exec(8'b00010110);
    manual_exec(8'b11010000);
    chk("post_abort_leds", LEDs, 4'b0110);
    start_run();
    wait_done(40, cyc, bok);
    $display("rerun cycles=%0d pc=%0d leds=%b", cyc, pc, LEDs);
    chk("rerun_cycles", cyc, 12);
    chk("rerun_pc", pc, 4'd6);
    chk("rerun_leds", LEDs, 4'b0000);
    finish_run();

    manual_exec(8'b11010000);
    chk("pre_nop_leds", LEDs, 4'b0110);
    load_prog(prog_nop);
    start_run();
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = 4'd10;
    prog_data = 8'b11000001;
    @(posedge clk);
    @(negedge clk);
    prog_we = 1'b0;
    wait_done(60, cyc, bok);
    $display("nop run cycles=%0d pc=%0d leds=%b", 1 + cyc, pc, LEDs);
    chk("nop_cycles", 1 + cyc, 32);
    chk("nop_pc_no_wrap", pc, 4'd15);
    chk("nop_busy", bok, 1'b1);
    chk("nop_leds", LEDs, 4'b0110);
    finish_run();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_nbit_processor.md
Name: param_nbit_processor

Overview:
- Parametrised successor to the team's 4-bit manual/run-mode CPU: data width, register count and program depth are set by parameters.
- Adds an on-chip program memory and a flags register (carry, zero).
- Adds SUB/AND/XOR, conditional skip, HALT, and explicit busy/Done handshakes.
- Executes either a single instruction from the instruction port (manual mode) or a stored program (run mode), and drives LEDs from the OUT instruction.

Parameters:
- DATA_W, 4: register/ALU/LED width; must be >= REG_AW+2.
- REG_AW, 2: register address bits; NREGS = 2**REG_AW.
- PC_W, 4: program counter width; PROG_DEPTH = 2**PC_W.
- INSTR_W, 2+REG_AW+DATA_W: derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- execute  in  1  start request, rising-edge detected internally.
- switch_mode  in  1  1 = manual (instruction port), 0 = run (program memory).
- pc_enable  in  1  run-mode advance enable; 0 stalls the fetch.
- instruction  in  INSTR_W  manual-mode instruction.
- prog_we  in  1  program memory write strobe; honoured only when busy=0.
- prog_addr  in  PC_W  program write address.
- prog_data  in  INSTR_W  program write data.
- LEDs  out  DATA_W  output register, written by OUT.
- Done  out  1  operation complete, level.
- busy  out  1  FSM not in IDLE/DONE.
- carry  out  1  carry/borrow flag.
- zero  out  1  zero flag.
- pc  out  PC_W  current program counter.

Behaviour:
- Encoding: [INSTR_W-1:INSTR_W-2] op; next REG_AW bits rd; low DATA_W bits imm. For register ops, rs = imm[DATA_W-1:DATA_W-REG_AW] and func = imm[1:0].
- op 00 LDI: rd <= imm. Flags unchanged.
- op 01 MOV: rd <= rs. Flags unchanged.
- op 10 ALU, result to rd, zero <= (result==0):
  - func 00 ADD: carry = carry-out.
  - func 01 SUB: rd-rs, modulo 2**DATA_W; carry = borrow (rd<rs).
  - func 10 AND / func 11 XOR: carry <= 0.
- op 11 CTL:
  - func 00 OUT: LEDs <= rd.
  - func 01 HALT.
  - func 10 BZ: skip next instruction if zero=1.
  - func 11 NOP.
- Reset (async, active-low): registers, LEDs, flags and pc go to 0; Done=0, busy=0, state IDLE. Program memory is not cleared.
- Execute edge: exec_q is registered; start = execute & ~exec_q.
- States: IDLE, FETCH, EXEC, DONE.
- IDLE:
  - start & switch_mode=1 -> EXEC, using the instruction port latched on the start cycle.
  - start & switch_mode=0 -> FETCH with pc=0.
  - No other transitions.
- FETCH: if pc_enable=1, latch ir <= mem[pc] and go to EXEC. Otherwise hold in FETCH.
- EXEC: writes take effect at the end of this cycle.
  - Manual mode -> DONE.
  - Run mode, HALT -> DONE; pc holds at the HALT address.
  - Run mode, pc==PROG_DEPTH-1 (no wrap) -> DONE.
  - Otherwise pc <= pc+1, or pc+2 on a taken BZ. If pc+2 overflows, go to DONE with pc=PROG_DEPTH-1. Then -> FETCH.
- Run-mode throughput: 2 cycles per instruction.
- DONE: Done=1. Stay while execute=1; go to IDLE once execute=0. Done stays 1 until that transition.
- busy=1 in FETCH and EXEC only.
- prog_we while busy=1 is ignored. Memory writes are synchronous.
- switch_mode changes are sampled only in IDLE.
- Reset mid-run: immediate return to IDLE; the program already loaded is retained.

Optional Feature:
- Macro: PROC_SHIFT_EN.
- Defined: CTL func 11 becomes SHL rd. rd <= rd<<1, carry <= old rd[DATA_W-1], zero updated.
- Undefined: CTL func 11 is NOP and no shifter is synthesised.

Test Plan:
- Defaults, manual mode:
  - Stimulus: LDI r0 (00001010), LDI r1 (00010101), ADD r0,r1 (10000100), OUT r0 (11000000), each via an execute pulse.
  - Response: LEDs=1111, carry=0, zero=0. Done rises 2 cycles after each execute edge and clears after execute falls.
- Overflow:
  - Stimulus: r0=1111, r1=0001, ADD.
  - Response: r0=0000, carry=1, zero=1. A following LDI leaves the flags unchanged.
- Borrow:
  - Stimulus: r0=0011, r1=0101, SUB (10000101), then OUT.
  - Response: LEDs=1110, carry=1. XOR r0,r0 (10000011) then gives zero=1, carry=0.
- Run mode program:
  - Program: 0 LDI r2,1; 1 LDI r3,1; 2 SUB r2,r3 (10101101); 3 BZ (11000010); 4 OUT r3 (11110000); 5 OUT r2 (11100000); 6 HALT (11000001).
  - Stimulus: switch_mode=0, pc_enable=1, execute pulse.
  - Response: LEDs=0000 (addr 4 skipped, r2=0); pc=6; Done after 12 cycles; busy high throughout.
- Stall and abort:
  - Stimulus 1: drop pc_enable for 5 cycles mid-run.
  - Response 1: pc frozen, busy=1; resumes with identical final LEDs.
  - Stimulus 2: reset low mid-run.
  - Response 2: same cycle LEDs=0, pc=0, Done=0, busy=0. A re-run reproduces the result (memory kept).
- No HALT:
  - Stimulus: all-NOP program.
  - Response: DONE at pc=1111 after 32 cycles, no wrap.
  - With PROC_SHIFT_EN: r0=1001, SHL gives r0=0010, carry=1.
